// File: rtl/conv_pkg.sv
// Shared definitions for the 2-D convolution engine: FSM states, header
// layout offsets, CTRL bit positions and memory operation encodings.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    CHECK = 3'd2,
    RD_A  = 3'd3,
    RD_F  = 3'd4,
    MAC   = 3'd5,
    WR    = 3'd6
  } state_t;

  localparam int unsigned HDR_WA   = 32'd0;
  localparam int unsigned HDR_HA   = 32'd1;
  localparam int unsigned HDR_WF   = 32'd2;
  localparam int unsigned HDR_HF   = 32'd3;
  localparam int unsigned HDR_CTRL = 32'd4;
  localparam int unsigned DATA_OFS = 32'd5;

  localparam int unsigned CTRL_SIGNED    = 32'd0;
  localparam int unsigned CTRL_RELU      = 32'd1;
  localparam int unsigned CTRL_SAT       = 32'd2;
  localparam int unsigned CTRL_STRIDE_LO = 32'd4;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b11;

endpackage

// File: rtl/conv_mac_unit.sv
// Multiply-accumulate with signed/unsigned extension, plus the ReLU and
// saturate/truncate stage that turns the accumulator into a DATA_W word.
module conv_mac_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              is_signed,
  input  logic              relu,
  input  logic              sat,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] f,
  output logic [DATA_W-1:0] result
);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] a_ext_s, f_ext_s, prod_s, staged_s;
  logic             sign_ok_s;

  // ACC_W >= 2*DATA_W, so the low ACC_W bits of the extended product are exact
  assign a_ext_s = is_signed ? {{(ACC_W-DATA_W){a[DATA_W-1]}}, a} : {{(ACC_W-DATA_W){1'b0}}, a};
  assign f_ext_s = is_signed ? {{(ACC_W-DATA_W){f[DATA_W-1]}}, f} : {{(ACC_W-DATA_W){1'b0}}, f};
  assign prod_s  = a_ext_s * f_ext_s;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + prod_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign sign_ok_s = (&staged_s[ACC_W-1:DATA_W-1]) | ~(|staged_s[ACC_W-1:DATA_W-1]);

  always_comb begin
    staged_s = acc_r;
    if (is_signed && relu && acc_r[ACC_W-1]) begin
      staged_s = '0;
    end else begin
      staged_s = acc_r;
    end
    result = staged_s[DATA_W-1:0];
    if (sat && is_signed) begin
      if (sign_ok_s) begin
        result = staged_s[DATA_W-1:0];
      end else begin
        result = staged_s[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
    end else if (sat) begin
      if (|staged_s[ACC_W-1:DATA_W]) begin
        result = {DATA_W{1'b1}};
      end else begin
        result = staged_s[DATA_W-1:0];
      end
    end else begin
      result = staged_s[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/conv2d_engine.sv
// Fetches header, input matrix and filter over the memory handshake and
// writes back the valid-region 2-D convolution, one MAC term at a time.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 64,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state_r, state_n;
  logic [ADDR_W-1:0] base_r, base_n, addr_r, addr_n;
  logic [DIM_W-1:0]  wa_r, wa_n, ha_r, ha_n, wf_r, wf_n, hf_r, hf_n;
  logic [DIM_W-1:0]  i_r, i_n, j_r, j_n, k_r, k_n, l_r, l_n;
  logic [DIM_W-1:0]  ow_r, ow_n, oh_r, oh_n;
  logic [3:0]        stride_r, stride_n, stride_s;
  logic              sgn_r, sgn_n, relu_r, relu_n, sat_r, sat_n;
  logic [2:0]        hdr_cnt_r, hdr_cnt_n;
  logic [DATA_W-1:0] a_val_r, a_val_n, f_val_r, f_val_n, data_r, data_n;
  logic [1:0]        op_r, op_n;
  logic              busy_r, busy_n, done_r, done_n, error_r, error_n;
  logic              start_d_r, start_edge_s, bad_dims_s, mac_clear_s, mac_en_s;
  logic [DATA_W-1:0] mac_result_s;
  logic [ADDR_W-1:0] stride_a_s, f_base_s, r_base_s, a_addr_s, f_addr_s, r_addr_s;

  assign start_edge_s = start & ~start_d_r;
  assign stride_s     = (stride_r == 4'd0) ? 4'd1 : stride_r;
  assign bad_dims_s   = (wa_r == '0) || (ha_r == '0) || (wf_r == '0) || (hf_r == '0)
                     || (wf_r > wa_r) || (hf_r > ha_r);

  assign stride_a_s = ADDR_W'(stride_s);
  assign f_base_s   = base_r + ADDR_W'(DATA_OFS) + ADDR_W'(wa_r) * ADDR_W'(ha_r);
  assign r_base_s   = f_base_s + ADDR_W'(wf_r) * ADDR_W'(hf_r);
  assign a_addr_s   = base_r + ADDR_W'(DATA_OFS)
                    + (ADDR_W'(i_r) * stride_a_s + ADDR_W'(k_r)) * ADDR_W'(wa_r)
                    + ADDR_W'(j_r) * stride_a_s + ADDR_W'(l_r);
  assign f_addr_s   = f_base_s + ADDR_W'(k_r) * ADDR_W'(wf_r) + ADDR_W'(l_r);
  assign r_addr_s   = r_base_s + ADDR_W'(i_r) * ADDR_W'(ow_r) + ADDR_W'(j_r);

  conv_mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .reset(reset), .clear(mac_clear_s), .en(mac_en_s),
    .is_signed(sgn_r), .relu(relu_r), .sat(sat_r),
    .a(a_val_r), .f(f_val_r), .result(mac_result_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;       base_r <= '0;      addr_r <= '0;
      wa_r <= '0; ha_r <= '0; wf_r <= '0; hf_r <= '0;
      i_r <= '0; j_r <= '0; k_r <= '0; l_r <= '0; ow_r <= '0; oh_r <= '0;
      stride_r <= 4'd0; sgn_r <= 1'b0; relu_r <= 1'b0; sat_r <= 1'b0;
      hdr_cnt_r <= 3'd0; a_val_r <= '0; f_val_r <= '0; data_r <= '0;
      op_r <= MEM_NONE; busy_r <= 1'b0; done_r <= 1'b0; error_r <= 1'b0;
      start_d_r <= 1'b0;
    end else begin
      state_r <= state_n;    base_r <= base_n;  addr_r <= addr_n;
      wa_r <= wa_n; ha_r <= ha_n; wf_r <= wf_n; hf_r <= hf_n;
      i_r <= i_n; j_r <= j_n; k_r <= k_n; l_r <= l_n; ow_r <= ow_n; oh_r <= oh_n;
      stride_r <= stride_n; sgn_r <= sgn_n; relu_r <= relu_n; sat_r <= sat_n;
      hdr_cnt_r <= hdr_cnt_n; a_val_r <= a_val_n; f_val_r <= f_val_n; data_r <= data_n;
      op_r <= op_n; busy_r <= busy_n; done_r <= done_n; error_r <= error_n;
      start_d_r <= start;
    end
  end

  // Each memory state spends one cycle with op=NONE issuing the request,
  // then holds it until mem_opdone, which guarantees the idle gap.
  always_comb begin
    state_n = state_r;   base_n = base_r;   addr_n = addr_r;
    wa_n = wa_r; ha_n = ha_r; wf_n = wf_r; hf_n = hf_r;
    i_n = i_r; j_n = j_r; k_n = k_r; l_n = l_r; ow_n = ow_r; oh_n = oh_r;
    stride_n = stride_r; sgn_n = sgn_r; relu_n = relu_r; sat_n = sat_r;
    hdr_cnt_n = hdr_cnt_r; a_val_n = a_val_r; f_val_n = f_val_r; data_n = data_r;
    op_n = op_r; busy_n = busy_r; done_n = done_r; error_n = error_r;
    mac_clear_s = 1'b0;  mac_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          base_n = base_addr_i; busy_n = 1'b1; done_n = 1'b0; error_n = 1'b0;
          hdr_cnt_n = 3'd0;     state_n = HDR;
        end else begin
          state_n = IDLE;
        end
      end
      HDR: begin
        if (op_r == MEM_NONE) begin
          addr_n = base_r + ADDR_W'(hdr_cnt_r);
          op_n   = MEM_RD;
        end else if (mem_opdone) begin
          op_n = MEM_NONE;
          case (hdr_cnt_r)
            3'(HDR_WA): wa_n = data_i[DIM_W-1:0];
            3'(HDR_HA): ha_n = data_i[DIM_W-1:0];
            3'(HDR_WF): wf_n = data_i[DIM_W-1:0];
            3'(HDR_HF): hf_n = data_i[DIM_W-1:0];
            3'(HDR_CTRL): begin
              sgn_n    = data_i[CTRL_SIGNED];
              relu_n   = data_i[CTRL_RELU];
              sat_n    = data_i[CTRL_SAT];
              stride_n = data_i[CTRL_STRIDE_LO +: 4];
            end
            default: wa_n = wa_r;
          endcase
          if (hdr_cnt_r == 3'(HDR_CTRL)) begin
            state_n = CHECK;
          end else begin
            hdr_cnt_n = hdr_cnt_r + 3'd1;
          end
        end else begin
          op_n = op_r;
        end
      end
      CHECK: begin
        if (bad_dims_s) begin
          error_n = 1'b1; done_n = 1'b1; busy_n = 1'b0; state_n = IDLE;
        end else begin
          i_n = '0; j_n = '0; k_n = '0; l_n = '0;
          ow_n = (wa_r - wf_r) / DIM_W'(stride_s) + DIM_W'(1);
          oh_n = (ha_r - hf_r) / DIM_W'(stride_s) + DIM_W'(1);
          mac_clear_s = 1'b1;
          state_n = RD_A;
        end
      end
      RD_A: begin
        if (op_r == MEM_NONE) begin
          addr_n = a_addr_s; op_n = MEM_RD;
        end else if (mem_opdone) begin
          a_val_n = data_i; op_n = MEM_NONE; state_n = RD_F;
        end else begin
          op_n = op_r;
        end
      end
      RD_F: begin
        if (op_r == MEM_NONE) begin
          addr_n = f_addr_s; op_n = MEM_RD;
        end else if (mem_opdone) begin
          f_val_n = data_i; op_n = MEM_NONE; state_n = MAC;
        end else begin
          op_n = op_r;
        end
      end
      MAC: begin
        mac_en_s = 1'b1;
        state_n  = RD_A;
        if (l_r + DIM_W'(1) != wf_r) begin
          l_n = l_r + DIM_W'(1);
        end else if (k_r + DIM_W'(1) != hf_r) begin
          l_n = '0; k_n = k_r + DIM_W'(1);
        end else begin
          l_n = '0; k_n = '0; state_n = WR;
        end
      end
      WR: begin
        if (op_r == MEM_NONE) begin
          addr_n = r_addr_s; data_n = mac_result_s; op_n = MEM_WR;
        end else if (mem_opdone) begin
          op_n = MEM_NONE; mac_clear_s = 1'b1; state_n = RD_A;
          if (j_r + DIM_W'(1) != ow_r) begin
            j_n = j_r + DIM_W'(1);
          end else if (i_r + DIM_W'(1) != oh_r) begin
            j_n = '0; i_n = i_r + DIM_W'(1);
          end else begin
            j_n = '0; i_n = '0; done_n = 1'b1; busy_n = 1'b0; state_n = IDLE;
          end
        end else begin
          op_n = op_r;
        end
      end
      default: begin
        op_n = MEM_NONE; busy_n = 1'b0; state_n = IDLE;
      end
    endcase
  end

  assign data_o        = data_r;
  assign addr_o        = addr_r;
  assign mem_operation = op_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: a stalling memory model answers requests,
// expected writes are queued by the stimulus and checked by a write monitor.
module tb_conv2d_engine;

  localparam int DW = 8, AW = 16, ACCW = 16, DMW = 8;

  logic          clk = 1'b0;
  logic          reset, start, mem_opdone;
  logic [AW-1:0] base_addr_i, addr_o;
  logic [DW-1:0] data_i, data_o;
  logic [1:0]    mem_operation;
  logic          busy, done, error;

  conv2d_engine #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(ACCW), .DIM_W(DMW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr_i(base_addr_i),
    .mem_opdone(mem_opdone), .data_i(data_i), .data_o(data_o), .addr_o(addr_o),
    .mem_operation(mem_operation), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [DW-1:0] mem [0:255];
  wr_t           exp_q[$];
  wr_t           mon_e;
  int            n_vec = 0, n_bad = 0, rd_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: random 0-7 cycle stall per request, checks request stability and the idle gap
  logic          active;
  int            stall;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  initial begin
    mem_opdone = 1'b0; data_i = '0; active = 1'b0; stall = 0;
    forever begin
      @(posedge clk); #1;
      if (reset === 1'b1) begin
        mem_opdone = 1'b0; active = 1'b0;
      end else if (mem_opdone) begin
        mem_opdone = 1'b0; active = 1'b0;
        chk("gap_after_ack", {30'd0, mem_operation}, 32'd0);
      end else if (mem_operation === 2'b01 || mem_operation === 2'b11) begin
        if (!active) begin
          active = 1'b1; req_addr = addr_o; req_op = mem_operation; req_data = data_o;
          stall = $urandom_range(0, 7);
        end else begin
          chk("req_stable", {addr_o, mem_operation, (req_op == 2'b11) ? data_o : req_data},
              {req_addr, req_op, req_data});
        end
        if (stall == 0) begin
          mem_opdone = 1'b1;
          if (mem_operation == 2'b01) begin
            data_i = mem[addr_o[7:0]]; rd_count++;
          end else begin
            mem[addr_o[7:0]] = data_o;
          end
        end else begin
          stall--;
        end
      end
    end
  end

  // Write monitor: every acknowledged write must match the head of the expected queue
  always @(negedge clk) begin
    if (reset === 1'b0 && mem_operation == 2'b11 && mem_opdone) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", addr_o, data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {16'd0, addr_o}, {16'd0, mon_e.addr});
        chk("wr_data", {24'd0, data_o}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic set_hdr(input int b, input int wa, input int ha, input int wf, input int hf, input int ctrl);
    mem[b] = DW'(wa); mem[b+1] = DW'(ha); mem[b+2] = DW'(wf); mem[b+3] = DW'(hf); mem[b+4] = DW'(ctrl);
  endtask

  task automatic expect_wr(input int a, input int d);
    wr_t e;
    e.addr = AW'(a); e.data = DW'(d);
    exp_q.push_back(e);
  endtask

  task automatic run_job(input int base, input logic exp_err, input logic poke);
    int cyc;
    @(negedge clk); base_addr_i = AW'(base); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_cleared", {31'd0, done}, 32'd0);
    chk("error_cleared", {31'd0, error}, 32'd0);
    if (poke) begin
      repeat (40) @(negedge clk);
      base_addr_i = '0; start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 5000) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    chk("job_in_time", {31'd0, cyc < 5000}, 32'd1);
    chk("done", {31'd0, done}, 32'd1);
    chk("error", {31'd0, error}, {31'd0, exp_err});
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("writes_left", exp_q.size(), 32'd0);
  endtask

  // 1x1 jobs: {ctrl, a, f, expected result}
  logic [7:0] one_tab [0:5][0:3] = '{
    '{8'h01, 8'hFD, 8'h02, 8'hFA},
    '{8'h03, 8'hFD, 8'h02, 8'h00},
    '{8'h04, 8'd200, 8'h02, 8'hFF},
    '{8'h00, 8'd200, 8'h02, 8'd144},
    '{8'h05, 8'h9C, 8'h02, 8'h80},
    '{8'h05, 8'd100, 8'h02, 8'h7F}
  };

  initial begin
    int cyc;
    for (int n = 0; n < 256; n++) mem[n] = '0;
    reset = 1'b1; start = 1'b0; base_addr_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_o", {24'd0, data_o}, 32'd0);
    chk("rst_addr_o", {16'd0, addr_o}, 32'd0);
    chk("rst_mem_op", {30'd0, mem_operation}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;

    // 3x3 A=1..9, 2x2 ones, stride field 0 (treated as 1)
    set_hdr(0, 3, 3, 2, 2, 8'h00);
    for (int n = 0; n < 9; n++) mem[5+n] = DW'(n + 1);
    for (int n = 0; n < 4; n++) mem[14+n] = 8'd1;
    expect_wr(18, 12); expect_wr(19, 16); expect_wr(20, 24); expect_wr(21, 28);
    run_job(0, 1'b0, 1'b0);

    // 5x5 A=0..24, 3x3 ones, stride 2, with an ignored start edge mid-job
    set_hdr(100, 5, 5, 3, 3, 8'h20);
    for (int n = 0; n < 25; n++) mem[105+n] = DW'(n);
    for (int n = 0; n < 9; n++) mem[130+n] = 8'd1;
    expect_wr(139, 54); expect_wr(140, 72); expect_wr(141, 144); expect_wr(142, 162);
    run_job(100, 1'b0, 1'b1);

    // bad dimensions: WF > WA, then a zero width
    set_hdr(50, 3, 3, 4, 1, 8'h00);
    run_job(50, 1'b1, 1'b0);
    set_hdr(60, 0, 3, 1, 1, 8'h00);
    run_job(60, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      set_hdr(200, 1, 1, 1, 1, one_tab[t][0]);
      mem[205] = one_tab[t][1]; mem[206] = one_tab[t][2];
      expect_wr(207, one_tab[t][3]);
      run_job(200, 1'b0, 1'b0);
    end

    // reset while an A read is pending: no writes may follow
    rd_count = 0;
    @(negedge clk); base_addr_i = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(rd_count >= 7 && mem_operation == 2'b01 && addr_o >= 16'd5 && addr_o <= 16'd13)
           && cyc < 5000) begin
      @(negedge clk); cyc++;
    end
    chk("reached_rd_a", {31'd0, cyc < 5000}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_mem_op", {30'd0, mem_operation}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_mem_op", {30'd0, mem_operation}, 32'd0);

    // clean restart after reset
    expect_wr(18, 12); expect_wr(19, 16); expect_wr(20, 24); expect_wr(21, 28);
    run_job(0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
